// File: rtl/regfile_scan_master_pkg.sv
// Shared types and defaults for the register-file scan master.
package regfile_scan_master_pkg;

  localparam int unsigned ADDR_W_DEF  = 4;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    NEXT = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_scan_master_if.sv
// Register read-back port plus dump stream of the scan master.
interface regfile_scan_master_if
  import regfile_scan_master_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              io_read_addr_valid;
  logic              io_read_addr_ready;
  logic [ADDR_W-1:0] io_read_addr_bits;
  logic              io_read_data_valid;
  logic              io_read_data_ready;
  logic [DATA_W-1:0] io_read_data_bits;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output io_read_addr_valid, io_read_addr_bits, io_read_data_ready,
    output dump_valid, dump_addr, dump_data,
    input  io_read_addr_ready, io_read_data_valid, io_read_data_bits,
    input  dump_ready
  );

  modport slave (
    input  io_read_addr_valid, io_read_addr_bits, io_read_data_ready,
    input  dump_valid, dump_addr, dump_data,
    output io_read_addr_ready, io_read_data_valid, io_read_data_bits,
    output dump_ready
  );

endinterface

// File: rtl/regfile_scan_master_scan_dump_slot.sv
// Single-entry valid/ready holding register; a load wins over a same-cycle drain.
module scan_dump_slot #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/regfile_scan_master.sv
// Sweeps register addresses first..last, forwards each word to the dump slot,
// accumulates a checksum and flags a per-read timeout.
module regfile_scan_master
  import regfile_scan_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            first_addr,
  input  logic [ADDR_W-1:0]            last_addr,
  regfile_scan_master_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [DATA_W-1:0]            checksum
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_end_addr;
  logic [7:0]        r_timer;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [DATA_W-1:0] r_checksum;

  logic              w_slot_free;
  logic              w_addr_valid;
  logic              w_data_ready;
  logic              w_addr_fire;
  logic              w_data_fire;
  logic              w_capture;
  logic              w_dump_valid;
  logic [ADDR_W-1:0] w_dump_addr;
  logic [DATA_W-1:0] w_dump_data;

  // A new request is only offered when its word is guaranteed a slot.
  assign w_slot_free  = !w_dump_valid || bus.dump_ready;
  assign w_addr_valid = (r_state == REQ) && w_slot_free;
  assign w_data_ready = (r_state == REQ) || (r_state == WAIT);
  assign w_addr_fire  = w_addr_valid && bus.io_read_addr_ready;
  assign w_data_fire  = w_data_ready && bus.io_read_data_valid;
  assign w_capture    = ((r_state == REQ) && w_addr_fire && w_data_fire) ||
                        ((r_state == WAIT) && w_data_fire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cur_addr <= '0;
      r_end_addr <= '0;
      r_timer    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_checksum <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_capture) begin
        r_checksum <= r_checksum + bus.io_read_data_bits;
      end
      case (r_state)
        IDLE: begin
          // r_done high means this is the done cycle; start is ignored there.
          if (start && !r_done) begin
            r_cur_addr <= first_addr;
            r_end_addr <= last_addr;
            r_checksum <= '0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (w_addr_fire) begin
            if (w_data_fire) begin
              r_state <= NEXT;
            end else begin
              r_timer <= '0;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (w_data_fire) begin
            r_state <= NEXT;
          end else if (r_timer == TIMEOUT_C) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        NEXT: begin
          if (r_cur_addr == r_end_addr) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cur_addr <= r_cur_addr + 1'b1;
            r_state    <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  scan_dump_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dump_slot (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_capture),
    .i_addr  (r_cur_addr),
    .i_data  (bus.io_read_data_bits),
    .i_ready (bus.dump_ready),
    .o_valid (w_dump_valid),
    .o_addr  (w_dump_addr),
    .o_data  (w_dump_data)
  );

  assign bus.io_read_addr_valid = w_addr_valid;
  assign bus.io_read_addr_bits  = r_cur_addr;
  assign bus.io_read_data_ready = w_data_ready;
  assign bus.dump_valid         = w_dump_valid;
  assign bus.dump_addr          = w_dump_addr;
  assign bus.dump_data          = w_dump_data;

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign checksum = r_checksum;

endmodule

// File: tb/tb_regfile_scan_master.sv
// Directed bench for regfile_scan_master with a mode-selectable core responder.
module tb_regfile_scan_master;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] checksum;

  int            errors = 0;
  int            checks = 0;

  // 0: zero-latency core (data = 0x100 + addr), 1: scripted, 2: never answers
  int            resp_mode = 0;
  logic          man_ready = 1'b0;
  logic          man_dvalid = 1'b0;
  logic [DW-1:0] man_dbits = '0;
  logic          dump_rdy = 1'b1;

  logic [AW-1:0] dq_a[$];
  logic [DW-1:0] dq_d[$];
  int            done_cnt = 0;
  int            afire_cnt = 0;

  regfile_scan_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_scan_master #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  assign bus.io_read_addr_ready = (resp_mode == 1) ? man_ready : 1'b1;
  assign bus.io_read_data_valid = (resp_mode == 0) ? bus.io_read_addr_valid :
                                  (resp_mode == 1) ? man_dvalid : 1'b0;
  assign bus.io_read_data_bits  = (resp_mode == 0) ? (32'h100 + 32'(bus.io_read_addr_bits)) : man_dbits;
  assign bus.dump_ready         = dump_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.dump_valid && bus.dump_ready) begin
      dq_a.push_back(bus.dump_addr);
      dq_d.push_back(bus.dump_data);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (bus.io_read_addr_valid && bus.io_read_addr_ready) afire_cnt <= afire_cnt + 1;
  end

  task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      n++;
      if (done) return;
    end
    n = -1;
  endtask

  task automatic clear_q();
    dq_a.delete();
    dq_d.delete();
  endtask

  task automatic manual_read(input logic [AW-1:0] exp_addr, input int stall, input int lat,
                             input logic [DW-1:0] word);
    int k = 0;
    while (!bus.io_read_addr_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (bus.io_read_addr_valid !== 1'b1) begin
      errors++; $display("FAIL req_valid: got %0b expected 1", bus.io_read_addr_valid);
    end
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (bus.io_read_addr_bits !== exp_addr || bus.io_read_addr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: got addr %0h valid %0b expected addr %0h valid 1",
                 bus.io_read_addr_bits, bus.io_read_addr_valid, exp_addr);
      end
      @(posedge clk); #1;
    end
    man_ready = 1'b1;
    @(posedge clk); #1;
    man_ready = 1'b0;
    checks++;
    if (bus.io_read_addr_valid !== 1'b0 || bus.io_read_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_state: got addr_valid %0b data_ready %0b expected 0 1",
               bus.io_read_addr_valid, bus.io_read_data_ready);
    end
    repeat (lat - 1) begin @(posedge clk); #1; end
    man_dvalid = 1'b1;
    man_dbits  = word;
    @(posedge clk); #1;
    man_dvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    #1;
    checks++;
    if ({busy, done, error, bus.dump_valid, bus.io_read_addr_valid, bus.io_read_data_ready} !== 6'b0 ||
        checksum !== '0 || bus.io_read_addr_bits !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy %0b done %0b err %0b dv %0b av %0b dr %0b cs %0h ab %0h expected all 0",
               busy, done, error, bus.dump_valid, bus.io_read_addr_valid, bus.io_read_data_ready,
               checksum, bus.io_read_addr_bits);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || bus.io_read_addr_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got busy %0b av %0b expected 0 0", busy, bus.io_read_addr_valid);
    end
  endtask

  task automatic test_full_sweep();
    int n;
    int d0;
    resp_mode = 0; dump_rdy = 1'b1;
    clear_q();
    d0 = done_cnt;
    do_start(4'd0, 4'd15);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %0b expected 1", busy); end
    wait_done(60, n);
    checks++;
    if (n !== 32) begin errors++; $display("FAIL full_latency: got %0d expected 32", n); end
    checks++;
    if (checksum !== 32'h0000_1078) begin errors++; $display("FAIL full_checksum: got %0h expected 1078", checksum); end
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL full_status: got busy %0b err %0b expected 0 0", busy, error);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done_once: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (dq_a.size() !== 16) begin errors++; $display("FAIL full_dump_count: got %0d expected 16", dq_a.size()); end
    for (int i = 0; i < 16 && i < dq_a.size(); i++) begin
      checks++;
      if (dq_a[i] !== AW'(i) || dq_d[i] !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL full_dump[%0d]: got %0h/%0h expected %0h/%0h", i, dq_a[i], dq_d[i], i, 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_stall_latency();
    int n;
    resp_mode = 1; dump_rdy = 1'b1;
    clear_q();
    do_start(4'd5, 4'd6);
    manual_read(4'd5, 3, 2, 32'hA5A5_0005);
    manual_read(4'd6, 0, 2, 32'h5A5A_0006);
    wait_done(5, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL stall_done: got %0d expected 1", n); end
    checks++;
    if (checksum !== 32'hFFFF_000B || error !== 1'b0) begin
      errors++; $display("FAIL stall_checksum: got %0h err %0b expected ffff000b 0", checksum, error);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (dq_a.size() !== 2) begin
      errors++; $display("FAIL stall_dump_count: got %0d expected 2", dq_a.size());
    end else begin
      checks++;
      if (dq_a[0] !== 4'd5 || dq_d[0] !== 32'hA5A5_0005 || dq_a[1] !== 4'd6 || dq_d[1] !== 32'h5A5A_0006) begin
        errors++;
        $display("FAIL stall_dumps: got %0h/%0h %0h/%0h expected 5/a5a50005 6/5a5a0006",
                 dq_a[0], dq_d[0], dq_a[1], dq_d[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    int a0;
    resp_mode = 0; dump_rdy = 1'b0;
    clear_q();
    a0 = afire_cnt;
    do_start(4'd0, 4'd3);
    repeat (10) begin @(posedge clk); #1; end
    checks++;
    if (bus.dump_valid !== 1'b1 || bus.dump_addr !== 4'd0 || bus.dump_data !== 32'h100) begin
      errors++;
      $display("FAIL bp_slot: got v %0b a %0h d %0h expected 1 0 100", bus.dump_valid, bus.dump_addr, bus.dump_data);
    end
    checks++;
    if (bus.io_read_addr_valid !== 1'b0 || bus.io_read_addr_bits !== 4'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got av %0b ab %0h busy %0b expected 0 1 1",
               bus.io_read_addr_valid, bus.io_read_addr_bits, busy);
    end
    checks++;
    if (afire_cnt - a0 !== 1 || dq_a.size() !== 0) begin
      errors++; $display("FAIL bp_no_issue: got fires %0d dumps %0d expected 1 0", afire_cnt - a0, dq_a.size());
    end
    dump_rdy = 1'b1;
    wait_done(40, n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL bp_done: got timeout expected done"); end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (dq_a.size() !== 4) begin errors++; $display("FAIL bp_dump_count: got %0d expected 4", dq_a.size()); end
    for (int i = 0; i < 4 && i < dq_a.size(); i++) begin
      checks++;
      if (dq_a[i] !== AW'(i) || dq_d[i] !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL bp_dump[%0d]: got %0h/%0h expected %0h/%0h", i, dq_a[i], dq_d[i], i, 32'h100 + 32'(i));
      end
    end
    checks++;
    if (checksum !== 32'h406) begin errors++; $display("FAIL bp_checksum: got %0h expected 406", checksum); end
  endtask

  task automatic test_wrap();
    int n;
    int d0;
    logic [AW-1:0] ea[4];
    ea[0] = 4'd14; ea[1] = 4'd15; ea[2] = 4'd0; ea[3] = 4'd1;
    resp_mode = 0; dump_rdy = 1'b1;
    clear_q();
    d0 = done_cnt;
    do_start(4'd14, 4'd1);
    wait_done(30, n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL wrap_latency: got %0d expected 8", n); end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL wrap_done_once: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (dq_a.size() !== 4) begin errors++; $display("FAIL wrap_dump_count: got %0d expected 4", dq_a.size()); end
    for (int i = 0; i < 4 && i < dq_a.size(); i++) begin
      checks++;
      if (dq_a[i] !== ea[i] || dq_d[i] !== 32'h100 + 32'(ea[i])) begin
        errors++; $display("FAIL wrap_dump[%0d]: got %0h/%0h expected %0h", i, dq_a[i], dq_d[i], ea[i]);
      end
    end
    checks++;
    if (checksum !== 32'h41E) begin errors++; $display("FAIL wrap_checksum: got %0h expected 41e", checksum); end
  endtask

  task automatic test_back_to_back();
    int n;
    resp_mode = 0; dump_rdy = 1'b1;
    clear_q();
    do_start(4'd0, 4'd3);
    repeat (2) begin @(posedge clk); #1; end
    do_start(4'd8, 4'd9);
    wait_done(20, n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL b2b_latency: got %0d expected 5", n); end
    do_start(4'd10, 4'd10);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_start_on_done: got busy %0b done %0b expected 0 0", busy, done);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (dq_a.size() !== 4 || checksum !== 32'h406) begin
      errors++; $display("FAIL b2b_ignore_busy: got dumps %0d cs %0h expected 4 406", dq_a.size(), checksum);
    end
  endtask

  task automatic test_timeout();
    int n;
    int d0;
    resp_mode = 2; dump_rdy = 1'b1;
    clear_q();
    d0 = done_cnt;
    do_start(4'd3, 4'd3);
    wait_done(TO + 20, n);
    checks++;
    if (n !== TO + 2) begin errors++; $display("FAIL to_latency: got %0d expected %0d", n, TO + 2); end
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || bus.dump_valid !== 1'b0) begin
      errors++; $display("FAIL to_status: got err %0b busy %0b dv %0b expected 1 0 0", error, busy, bus.dump_valid);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (done_cnt - d0 !== 1 || error !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got done %0d err %0b expected 1 1", done_cnt - d0, error);
    end
    resp_mode = 0;
    do_start(4'd2, 4'd2);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL to_clear: got err %0b busy %0b expected 0 1", error, busy);
    end
    wait_done(10, n);
    checks++;
    if (n !== 2 || checksum !== 32'h102) begin
      errors++; $display("FAIL to_resweep: got n %0d cs %0h expected 2 102", n, checksum);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    resp_mode = 0; dump_rdy = 1'b1;
    do_start(4'd0, 4'd15);
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, bus.dump_valid, bus.io_read_addr_valid, bus.io_read_data_ready} !== 6'b0 ||
        checksum !== '0 || bus.io_read_addr_bits !== '0 || bus.dump_addr !== '0 || bus.dump_data !== '0) begin
      errors++;
      $display("FAIL midreset_zero: got busy %0b dv %0b av %0b dr %0b cs %0h ab %0h expected all 0",
               busy, bus.dump_valid, bus.io_read_addr_valid, bus.io_read_data_ready, checksum, bus.io_read_addr_bits);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    clear_q();
    do_start(4'd0, 4'd15);
    wait_done(60, n);
    checks++;
    if (n !== 32 || checksum !== 32'h1078) begin
      errors++; $display("FAIL midreset_sweep: got n %0d cs %0h expected 32 1078", n, checksum);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (dq_a.size() !== 16) begin
      errors++; $display("FAIL midreset_dumps: got %0d expected 16", dq_a.size());
    end else begin
      checks++;
      if (dq_a[0] !== 4'd0 || dq_a[15] !== 4'd15 || dq_d[15] !== 32'h10F) begin
        errors++; $display("FAIL midreset_order: got %0h %0h/%0h expected 0 f/10f", dq_a[0], dq_a[15], dq_d[15]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_stall_latency();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
